lsu_tlbwrdp: RTL and testbench

- Write-side datapath and sequencer for the DTLB. It is the inverse of the TLB read formatter.
- Accepts 64-bit ASI store data for the tag-access, data-in and data-access registers, and unpacks the architectural TTE into the STLB tag/data field layout defined in lsu.h.
- Generates the mux-select/VA-valid bits and tag/data parity, then holds a write request to the TLB until it is acknowledged.
- Sits between the LSU ASI store path (g-stage) and the DTLB write port.

---
 rtl/lsu_tlbwrdp_if.sv | 19 +
 rtl/lsu_tlbwrdp.sv | 196 +++++++++++++++++++
 tb/tb_lsu_tlbwrdp.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_tlbwrdp_if.sv
// DTLB write-port bundle between lsu_tlbwrdp (master) and the DTLB (slave).
interface lsu_tlbwrdp_if;
  logic        tlb_wr_vld;
  logic [58:0] tlb_wr_tte_tag;
  logic [42:0] tlb_wr_tte_data;
  logic [5:0]  tlb_wr_index;
  logic        tlb_wr_index_vld;
  logic        tlb_wr_ack;

  modport master (
    output tlb_wr_vld, tlb_wr_tte_tag, tlb_wr_tte_data, tlb_wr_index, tlb_wr_index_vld,
    input  tlb_wr_ack
  );

  modport slave (
    input  tlb_wr_vld, tlb_wr_tte_tag, tlb_wr_tte_data, tlb_wr_index, tlb_wr_index_vld,
    output tlb_wr_ack
  );
endinterface

// File: rtl/lsu_tlbwrdp.sv
// DTLB write datapath: unpacks ASI store data into STLB tag/data layout and holds the
// write request until acked. Define LSU_TLBWR_TIMEOUT_EN to add an abort timer.
module lsu_tlbwrdp #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          rclk,
  input  logic          reset,
  input  logic          se,
  input  logic          si,
  output logic          so,
  input  logic [63:0]   lsu_st_data_g,
  input  logic          tag_access_wr_g,
  input  logic          data_in_wr_g,
  input  logic          data_access_wr_g,
  input  logic [5:0]    lsu_ldst_va_g,
  lsu_tlbwrdp_if.master tlb,
  output logic          lsu_tlbwr_busy,
  output logic          lsu_tlbwr_done,
  output logic          lsu_tlbwr_drop
`ifdef LSU_TLBWR_TIMEOUT_EN
  ,
  output logic          lsu_tlbwr_timeout
`endif
);

  // STLB tag field positions
  localparam int T_V          = 58;
  localparam int T_U          = 57;
  localparam int T_VA_27_22_V = 56;
  localparam int T_VA_21_16_V = 55;
  localparam int T_PARITY     = 54;
  localparam int T_VA_HI_MSB  = 53;   // VA[47:22]
  localparam int T_VA_HI_LSB  = 28;
  localparam int T_VA_15_13_V = 27;
  localparam int T_VA_LO_MSB  = 23;   // VA[21:13]
  localparam int T_VA_LO_LSB  = 15;
  localparam int T_CTX_MSB    = 12;   // context[12:0]

  // STLB data field positions
  localparam int D_PARITY     = 42;
  localparam int D_NFO        = 41;
  localparam int D_IE         = 40;
  localparam int D_PA_MSB     = 39;   // PA[39:13] kept bit-aligned
  localparam int D_PA_LSB     = 13;
  localparam int D_SEL_27_22  = 12;
  localparam int D_SEL_21_16  = 11;
  localparam int D_SEL_15_13  = 10;
  localparam int D_L          = 6;
  localparam int D_CP         = 5;
  localparam int D_CV         = 4;
  localparam int D_E          = 3;
  localparam int D_P          = 2;
  localparam int D_W          = 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  typedef struct packed {
    state_t      state;
    logic [47:0] tag_access;
    logic        vld;
    logic [58:0] tag;
    logic [42:0] data;
    logic [5:0]  index;
    logic        index_vld;
    logic        done;
    logic        drop;
`ifdef LSU_TLBWR_TIMEOUT_EN
    logic [7:0]  cnt;
    logic        timeout;
`endif
  } regs_t;

  localparam int REGS_W = $bits(regs_t);

  regs_t       r;
  logic [63:0] d;
  logic [2:0]  sz;
  logic [2:0]  sel;
  logic [58:0] fmt_tag;
  logic [42:0] fmt_data;
  logic        start;
  logic        unused_bits;

  assign d     = lsu_st_data_g;
  assign sz    = {d[48], d[62:61]};
  assign start = data_in_wr_g | data_access_wr_g;

  // Reserved size encodings fall back to 8K.
  always_comb begin
    case (sz)
      3'b001:  sel = 3'b001;
      3'b011:  sel = 3'b011;
      3'b101:  sel = 3'b111;
      default: sel = 3'b000;
    endcase
  end

  always_comb begin
    fmt_data                     = '0;
    fmt_data[D_NFO]              = d[60];
    fmt_data[D_IE]               = d[59];
    fmt_data[D_PA_MSB:D_PA_LSB]  = d[39:13];
    fmt_data[D_SEL_27_22]        = sel[2];
    fmt_data[D_SEL_21_16]        = sel[1];
    fmt_data[D_SEL_15_13]        = sel[0];
    fmt_data[D_L]                = d[6];
    fmt_data[D_CP]               = d[5];
    fmt_data[D_CV]               = d[4];
    fmt_data[D_E]                = d[3];
    fmt_data[D_P]                = d[2];
    fmt_data[D_W]                = d[1];
    fmt_data[D_PARITY]           = ^fmt_data[D_PARITY-1:0];
  end

  // Parity covers the same bits the read-side checker folds, skipping the parity slot.
  always_comb begin
    fmt_tag                            = '0;
    fmt_tag[T_V]                       = d[63];
    fmt_tag[T_U]                       = d[47];
    fmt_tag[T_VA_27_22_V]              = ~sel[2];
    fmt_tag[T_VA_21_16_V]              = ~sel[1];
    fmt_tag[T_VA_15_13_V]              = ~sel[0];
    fmt_tag[T_VA_HI_MSB:T_VA_HI_LSB]   = r.tag_access[47:22];
    fmt_tag[T_VA_LO_MSB:T_VA_LO_LSB]   = r.tag_access[21:13];
    fmt_tag[T_CTX_MSB:0]               = r.tag_access[12:0];
    fmt_tag[T_PARITY]                  = ^{fmt_tag[58:55], fmt_tag[53:27], fmt_tag[25], fmt_tag[23:0]};
  end

  // Every flop lives in one packed struct so scan shifts it as a single chain.
  always_ff @(posedge rclk) begin
    if (reset) begin
      r <= '0;
    end else if (se) begin
      r <= regs_t'({r[REGS_W-2:0], si});
    end else begin
      // NOTE: non-blocking throughout; each field below reads last cycle's r.
      r.done <= 1'b0;
      r.drop <= 1'b0;
`ifdef LSU_TLBWR_TIMEOUT_EN
      r.timeout <= 1'b0;
`endif
      if (tag_access_wr_g) r.tag_access <= d[47:0];
      case (r.state)
        IDLE: begin
          if (start) begin
            r.state     <= REQ;
            r.vld       <= 1'b1;
            r.tag       <= fmt_tag;
            r.data      <= fmt_data;
            r.index     <= data_access_wr_g ? lsu_ldst_va_g : 6'd0;
            r.index_vld <= data_access_wr_g;
`ifdef LSU_TLBWR_TIMEOUT_EN
            r.cnt       <= 8'd0;
`endif
          end
        end
        REQ: begin
          if (start) r.drop <= 1'b1;
          if (tlb.tlb_wr_ack) begin
            r.state <= IDLE;
            r.vld   <= 1'b0;
            r.done  <= 1'b1;
          end
`ifdef LSU_TLBWR_TIMEOUT_EN
          else if (r.cnt == 8'(TIMEOUT_CYC - 1)) begin
            r.state   <= IDLE;
            r.vld     <= 1'b0;
            r.timeout <= 1'b1;
          end else begin
            r.cnt <= r.cnt + 8'd1;
          end
`endif
        end
        default: r.state <= IDLE;
      endcase
    end
  end

  assign so                   = r[REGS_W-1];
  assign tlb.tlb_wr_vld       = r.vld;
  assign tlb.tlb_wr_tte_tag   = r.tag;
  assign tlb.tlb_wr_tte_data  = r.data;
  assign tlb.tlb_wr_index     = r.index;
  assign tlb.tlb_wr_index_vld = r.index_vld;
  assign lsu_tlbwr_busy       = (r.state == REQ);
  assign lsu_tlbwr_done       = r.done;
  assign lsu_tlbwr_drop       = r.drop;

`ifdef LSU_TLBWR_TIMEOUT_EN
  assign lsu_tlbwr_timeout = r.timeout;
  assign unused_bits       = ^d[58:49];
`else
  assign unused_bits       = ^{d[58:49], TIMEOUT_CYC[0]};
`endif

endmodule

// File: tb/tb_lsu_tlbwrdp.sv
// Self-checking bench for lsu_tlbwrdp: directed steps plus random traffic against a
// transaction-level model of the write sequencer and the STLB field layout.
module tb_lsu_tlbwrdp;

  localparam int TO = 4;

  logic        rclk = 1'b0;
  logic        reset, se, si, so;
  logic [63:0] lsu_st_data_g;
  logic        tag_access_wr_g, data_in_wr_g, data_access_wr_g;
  logic [5:0]  lsu_ldst_va_g;
  logic        lsu_tlbwr_busy, lsu_tlbwr_done, lsu_tlbwr_drop;
`ifdef LSU_TLBWR_TIMEOUT_EN
  logic        lsu_tlbwr_timeout;
`endif

  lsu_tlbwrdp_if tlb_if ();

  always #5 rclk = ~rclk;

  lsu_tlbwrdp #(.TIMEOUT_CYC(TO)) dut (
    .rclk             (rclk),
    .reset            (reset),
    .se               (se),
    .si               (si),
    .so               (so),
    .lsu_st_data_g    (lsu_st_data_g),
    .tag_access_wr_g  (tag_access_wr_g),
    .data_in_wr_g     (data_in_wr_g),
    .data_access_wr_g (data_access_wr_g),
    .lsu_ldst_va_g    (lsu_ldst_va_g),
    .tlb              (tlb_if),
    .lsu_tlbwr_busy   (lsu_tlbwr_busy),
    .lsu_tlbwr_done   (lsu_tlbwr_done),
    .lsu_tlbwr_drop   (lsu_tlbwr_drop)
`ifdef LSU_TLBWR_TIMEOUT_EN
    ,
    .lsu_tlbwr_timeout(lsu_tlbwr_timeout)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_busy, m_vld, m_done, m_drop, m_to, m_idxv;
  logic [58:0] m_tag;
  logic [42:0] m_data;
  logic [5:0]  m_idx;
  logic [63:0] m_ta;
  int          m_age;

  // Page-size code -> {sel2,sel1,sel0}
  logic [2:0] sel_tbl [8] = '{3'd0, 3'd1, 3'd0, 3'd3, 3'd0, 3'd7, 3'd0, 3'd0};

  function automatic logic [58:0] exp_tag(input logic [63:0] ta, input logic [63:0] dd,
                                          input logic [2:0] s);
    logic [58:0] t;
    t = {dd[63], dd[47], ~s[2], ~s[1], 1'b0, ta[47:22], ~s[0], 3'b000,
         ta[21:13], 2'b00, ta[12:0]};
    t[54] = 1'($countones(t) % 2);
    return t;
  endfunction

  function automatic logic [42:0] exp_data(input logic [63:0] dd, input logic [2:0] s);
    logic [42:0] x;
    x = {1'b0, dd[60], dd[59], dd[39:13], s, 3'b000, dd[6:1], 1'b0};
    x[42] = 1'($countones(x) % 2);
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic       st;
    logic [2:0] s;
    st = data_in_wr_g | data_access_wr_g;
    m_done = 1'b0; m_drop = 1'b0; m_to = 1'b0;
    if (reset) begin
      m_busy = 0; m_idxv = 0; m_tag = '0; m_data = '0; m_idx = '0; m_ta = '0; m_age = 0;
    end else begin
      if (m_busy) begin
        if (st) m_drop = 1'b1;
        if (tlb_if.tlb_wr_ack) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
`ifdef LSU_TLBWR_TIMEOUT_EN
        else begin
          m_age++;
          if (m_age == TO) begin
            m_busy = 1'b0;
            m_to   = 1'b1;
          end
        end
`endif
      end else if (st) begin
        s      = sel_tbl[{lsu_st_data_g[48], lsu_st_data_g[62:61]}];
        m_tag  = exp_tag(m_ta, lsu_st_data_g, s);
        m_data = exp_data(lsu_st_data_g, s);
        m_idxv = data_access_wr_g;
        m_idx  = data_access_wr_g ? lsu_ldst_va_g : 6'd0;
        m_busy = 1'b1;
        m_age  = 0;
      end
      if (tag_access_wr_g) m_ta = lsu_st_data_g;
    end
    m_vld = m_busy;
  endtask

  task automatic check_all();
    check("vld",       64'(tlb_if.tlb_wr_vld),       64'(m_vld));
    check("tte_tag",   64'(tlb_if.tlb_wr_tte_tag),   64'(m_tag));
    check("tte_data",  64'(tlb_if.tlb_wr_tte_data),  64'(m_data));
    check("index",     64'(tlb_if.tlb_wr_index),     64'(m_idx));
    check("index_vld", 64'(tlb_if.tlb_wr_index_vld), 64'(m_idxv));
    check("busy",      64'(lsu_tlbwr_busy),          64'(m_busy));
    check("done",      64'(lsu_tlbwr_done),          64'(m_done));
    check("drop",      64'(lsu_tlbwr_drop),          64'(m_drop));
`ifdef LSU_TLBWR_TIMEOUT_EN
    check("timeout",   64'(lsu_tlbwr_timeout),       64'(m_to));
`endif
  endtask

  // Sample #1 after the edge; the model consumes the inputs that the edge saw.
  task automatic tick();
    @(posedge rclk);
    #1;
    model_update();
    check_all();
  endtask

  task automatic clear_inputs();
    tag_access_wr_g = 0; data_in_wr_g = 0; data_access_wr_g = 0; tlb_if.tlb_wr_ack = 0;
  endtask

  task automatic start_write(input logic [63:0] dd, input logic din, input logic dacc,
                             input logic [5:0] va);
    lsu_st_data_g = dd; data_in_wr_g = din; data_access_wr_g = dacc; lsu_ldst_va_g = va;
    tick();
    clear_inputs();
  endtask

  task automatic ack_after(input int waits);
    for (int i = 0; i < waits; i++) tick();
    tlb_if.tlb_wr_ack = 1;
    tick();
    tlb_if.tlb_wr_ack = 0;
  endtask

  logic [63:0] dv;
  logic [2:0]  sz_list [5] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b010};
  int          vld_cycles, done_pulses;
  logic        found;

  initial begin
    reset = 1; se = 0; si = 0; lsu_st_data_g = '0; lsu_ldst_va_g = '0;
    clear_inputs();
    m_ta = '0;

    // Reset state
    tick(); tick();
    check("reset_so", 64'(so), 64'(0));
    reset = 0;

    // Tag-access load, then replacement write acked on the second vld cycle
    lsu_st_data_g = 64'h0000_1234_5678_A005; tag_access_wr_g = 1;
    tick();
    clear_inputs();
    dv = 64'h8000_0000_1234_E07E;
    start_write(dv, 1'b1, 1'b0, 6'h11);
    check("tp1_ctx",      64'(tlb_if.tlb_wr_tte_tag[12:0]), 64'(13'h0005));
    check("tp1_v",        64'(tlb_if.tlb_wr_tte_tag[58]), 64'(1));
    check("tp1_va_valid", 64'({tlb_if.tlb_wr_tte_tag[56], tlb_if.tlb_wr_tte_tag[55],
                               tlb_if.tlb_wr_tte_tag[27]}), 64'(3'b111));
    check("tp1_sel",      64'(tlb_if.tlb_wr_tte_data[12:10]), 64'(3'b000));
    check("tp1_pa",       64'(tlb_if.tlb_wr_tte_data[39:13]), 64'(dv[39:13]));
    check("tp1_attr",     64'(tlb_if.tlb_wr_tte_data[6:1]), 64'(6'h3F));
    vld_cycles = 0; done_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      vld_cycles  += int'(tlb_if.tlb_wr_vld);
      tlb_if.tlb_wr_ack = (i == 1);
      tick();
      done_pulses += int'(lsu_tlbwr_done);
    end
    tlb_if.tlb_wr_ack = 0;
    check("tp1_vld_cycles", 64'(vld_cycles), 64'(2));
    check("tp1_done_pulses", 64'(done_pulses), 64'(1));

    // Indexed write, 256M page, both strobes high; ack in first REQ cycle
    dv = {$urandom, $urandom};
    dv[48] = 1'b1; dv[62:61] = 2'b01;
    start_write(dv, 1'b1, 1'b1, 6'h2A);
    check("idx_index",     64'(tlb_if.tlb_wr_index), 64'(6'h2A));
    check("idx_index_vld", 64'(tlb_if.tlb_wr_index_vld), 64'(1));
    check("idx_sel",       64'(tlb_if.tlb_wr_tte_data[12:10]), 64'(3'b111));
    check("idx_va_valid",  64'({tlb_if.tlb_wr_tte_tag[56], tlb_if.tlb_wr_tte_tag[55],
                                tlb_if.tlb_wr_tte_tag[27]}), 64'(3'b000));
    ack_after(0);
    check("idx_done", 64'(lsu_tlbwr_done), 64'(1));
    tick();

    // Page-size sweep including a reserved encoding
    foreach (sz_list[k]) begin
      dv = {$urandom, $urandom};
      dv[48] = sz_list[k][2]; dv[62:61] = sz_list[k][1:0];
      lsu_st_data_g = dv; tag_access_wr_g = 1;
      tick();
      clear_inputs();
      dv = {$urandom, $urandom};
      dv[48] = sz_list[k][2]; dv[62:61] = sz_list[k][1:0];
      start_write(dv, 1'b1, 1'b0, 6'($urandom));
      check("sweep_sel", 64'(tlb_if.tlb_wr_tte_data[12:10]), 64'(sel_tbl[sz_list[k]]));
      ack_after(int'($urandom_range(0, 3)));
      tick();
    end

    // Start while busy is dropped; tag-access load in flight is harmless
    dv = {$urandom, $urandom};
    start_write(dv, 1'b1, 1'b0, 6'h00);
    lsu_st_data_g = {$urandom, $urandom}; data_in_wr_g = 1; tag_access_wr_g = 1;
    tick();
    clear_inputs();
    check("busy_drop", 64'(lsu_tlbwr_drop), 64'(1));
    tick();
    tlb_if.tlb_wr_ack = 1;
    tick();
    check("drop_done", 64'(lsu_tlbwr_done), 64'(1));
    // Start in the done cycle is accepted
    dv = {$urandom, $urandom};
    start_write(dv, 1'b0, 1'b1, 6'h15);
    check("done_cycle_start", 64'(tlb_if.tlb_wr_vld), 64'(1));
    ack_after(1);
    // Ack while idle is ignored
    tlb_if.tlb_wr_ack = 1;
    tick(); tick();
    tlb_if.tlb_wr_ack = 0;

    // Reset in the third REQ cycle
    start_write({$urandom, $urandom}, 1'b1, 1'b0, 6'h00);
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    check("rst_mid_vld", 64'(tlb_if.tlb_wr_vld), 64'(0));
    check("rst_mid_tag", 64'(tlb_if.tlb_wr_tte_tag), 64'(0));
    tick();

`ifdef LSU_TLBWR_TIMEOUT_EN
    // Never-acked request aborts after TO REQ cycles
    start_write({$urandom, $urandom}, 1'b1, 1'b0, 6'h00);
    found = 0;
    for (int i = 0; i < 3 * TO && !found; i++) begin
      tick();
      if (lsu_tlbwr_timeout === 1'b1) begin
        found = 1;
        check("to_cycles", 64'(i + 2), 64'(TO + 1));
        check("to_busy", 64'(lsu_tlbwr_busy), 64'(0));
      end
    end
    check("to_seen", 64'(found), 64'(1));
    tick();
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      lsu_st_data_g    = {$urandom, $urandom};
      lsu_ldst_va_g    = 6'($urandom);
      tag_access_wr_g  = ($urandom_range(0, 3) == 0);
      data_in_wr_g     = ($urandom_range(0, 4) == 0);
      data_access_wr_g = ($urandom_range(0, 6) == 0);
      tlb_if.tlb_wr_ack = ($urandom_range(0, 2) == 0);
      reset            = ($urandom_range(0, 96) == 0);
      tick();
    end
    clear_inputs();
    reset = 0;
    tick();

    // Scan: ones then zeros must traverse the chain within a bounded number of shifts
    se = 1; si = 1; found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge rclk); #1;
      if (so === 1'b1) found = 1;
    end
    check("scan_ones", 64'(found), 64'(1));
    si = 0; found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge rclk); #1;
      if (so === 1'b0) found = 1;
    end
    check("scan_zeros", 64'(found), 64'(1));
    se = 0; reset = 1;
    tick();
    reset = 0;
    check("post_scan_so", 64'(so), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
